// File: rtl/tmds_period_decode.sv
// HDMI receive-side period tracker: classifies raw TMDS symbols, follows the
// preamble/guard-band sequencing and emits decoded video and TERC4 island data.
module tmds_period_decode #(
  parameter int PREAMBLE_LEN = 8,
  parameter int PACKET_LEN   = 32,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           in0,
  input  logic [9:0]           in1,
  input  logic [9:0]           in2,
  output logic [2:0]           state,
  output logic                 video_valid,
  output logic [23:0]          rgb,
  output logic                 island_valid,
  output logic [11:0]          island_data,
  output logic                 packet_start,
  output logic                 hsync,
  output logic                 vsync,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam int CW = $clog2(PREAMBLE_LEN + 1);
  localparam int PW = $clog2(PACKET_LEN + 1);
  localparam logic [CW-1:0] PRE_MAX  = CW'(PREAMBLE_LEN);
  localparam logic [PW-1:0] PKT_LAST = PW'(PACKET_LEN - 1);
  localparam logic [9:0] GB_A = 10'b1011001100;
  localparam logic [9:0] GB_B = 10'b0100110011;

  typedef enum logic [2:0] {
    CONTROL = 3'd0, VID_GUARD = 3'd1, VIDEO = 3'd2,
    ISL_LEAD = 3'd3, ISLAND = 3'd4, ISL_TRAIL = 3'd5
  } period_t;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic       is_terc;
    logic [3:0] terc;
    logic [7:0] dat;
  } sym_t;

  function automatic sym_t classify(input logic [9:0] s);
    sym_t       r;
    logic [7:0] q;
    r = '0;
    case (s)
      10'b1101010100: begin r.is_ctrl = 1'b1; r.ctrl = 2'd0; end
      10'b0010101011: begin r.is_ctrl = 1'b1; r.ctrl = 2'd1; end
      10'b0101010100: begin r.is_ctrl = 1'b1; r.ctrl = 2'd2; end
      10'b1010101011: begin r.is_ctrl = 1'b1; r.ctrl = 2'd3; end
      default: ;
    endcase
    r.is_terc = 1'b1;
    case (s)
      10'b1010011100: r.terc = 4'h0;
      10'b1001100011: r.terc = 4'h1;
      10'b1011100100: r.terc = 4'h2;
      10'b1011100010: r.terc = 4'h3;
      10'b0101110001: r.terc = 4'h4;
      10'b0100011110: r.terc = 4'h5;
      10'b0110001110: r.terc = 4'h6;
      10'b0100111100: r.terc = 4'h7;
      10'b1011001100: r.terc = 4'h8;
      10'b0100111001: r.terc = 4'h9;
      10'b0110011100: r.terc = 4'hA;
      10'b1011000110: r.terc = 4'hB;
      10'b1010001110: r.terc = 4'hC;
      10'b1001110001: r.terc = 4'hD;
      10'b0101100011: r.terc = 4'hE;
      10'b1011000011: r.terc = 4'hF;
      default:        r.is_terc = 1'b0;
    endcase
    // bit 9 undoes DC-balance inversion, bit 8 selects XOR vs XNOR chaining
    q = s[9] ? ~s[7:0] : s[7:0];
    r.dat[0] = q[0];
    for (int i = 1; i < 8; i++)
      r.dat[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return r;
  endfunction

  sym_t k0, k1, k2;
  sym_t p0, p1, p2;
  logic p_vgd, p_igd;

  assign k0 = classify(in0);
  assign k1 = classify(in1);
  assign k2 = classify(in2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0    <= '0;
      p1    <= '0;
      p2    <= '0;
      p_vgd <= 1'b0;
      p_igd <= 1'b0;
    end else begin
      p0    <= k0;
      p1    <= k1;
      p2    <= k2;
      p_vgd <= (in0 == GB_A) && (in1 == GB_B) && (in2 == GB_A);
      p_igd <= k0.is_terc && (in1 == GB_B) && (in2 == GB_B);
    end
  end

  period_t        st;
  logic [CW-1:0]  pre_cnt, pre_cnt_n;
  logic           pre_isl, pre_isl_n;
  logic [PW-1:0]  pkt;
  logic           all_ctrl, all_terc, vid_pre, isl_pre, arm_vid, arm_isl, sym_err;

  assign all_ctrl = p0.is_ctrl && p1.is_ctrl && p2.is_ctrl;
  assign all_terc = p0.is_terc && p1.is_terc && p2.is_terc;
  assign vid_pre  = all_ctrl && (p2.ctrl == 2'b00) && (p1.ctrl == 2'b01);
  assign isl_pre  = all_ctrl && (p2.ctrl == 2'b01) && (p1.ctrl == 2'b01);
  // a period is armed exactly while the saturating count sits at its maximum
  assign arm_vid  = (pre_cnt == PRE_MAX) && !pre_isl;
  assign arm_isl  = (pre_cnt == PRE_MAX) && pre_isl;

  always_comb begin
    pre_cnt_n = '0;
    pre_isl_n = 1'b0;
    if (vid_pre || isl_pre) begin
      pre_isl_n = isl_pre;
      if (pre_cnt != '0 && pre_isl == isl_pre)
        pre_cnt_n = (pre_cnt == PRE_MAX) ? PRE_MAX : pre_cnt + CW'(1);
      else
        pre_cnt_n = CW'(1);
    end
  end

  always_comb begin
    sym_err = 1'b0;
    case (st)
      VID_GUARD: sym_err = !p_vgd;
      ISL_LEAD:  sym_err = !p_igd;
      ISL_TRAIL: sym_err = !p_igd;
      ISLAND:    sym_err = !(pkt == '0 && p_igd) && !all_terc;
      default:   sym_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= CONTROL;
      pre_cnt      <= '0;
      pre_isl      <= 1'b0;
      pkt          <= '0;
      video_valid  <= 1'b0;
      rgb          <= '0;
      island_valid <= 1'b0;
      island_data  <= '0;
      packet_start <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      err_count    <= '0;
    end else begin
      video_valid  <= 1'b0;
      island_valid <= 1'b0;
      packet_start <= 1'b0;
      if (sym_err && err_count != '1)
        err_count <= err_count + ERR_WIDTH'(1);
      if (p0.is_ctrl) begin
        hsync <= p0.ctrl[0];
        vsync <= p0.ctrl[1];
      end else if (p0.is_terc && (st == ISL_LEAD || st == ISLAND || st == ISL_TRAIL)) begin
        hsync <= p0.terc[0];
        vsync <= p0.terc[1];
      end
      case (st)
        CONTROL: begin
          pre_cnt <= pre_cnt_n;
          pre_isl <= pre_isl_n;
          if (arm_vid && p_vgd) begin
            st      <= VID_GUARD;
            pre_cnt <= '0;
          end else if (arm_isl && p_igd) begin
            st      <= ISL_LEAD;
            pre_cnt <= '0;
          end
        end
        VID_GUARD: st <= p_vgd ? VIDEO : CONTROL;
        VIDEO: begin
          if (p0.is_ctrl) begin
            st      <= CONTROL;
            pre_cnt <= pre_cnt_n;
            pre_isl <= pre_isl_n;
          end else begin
            video_valid <= 1'b1;
            rgb         <= {p2.dat, p1.dat, p0.dat};
          end
        end
        ISL_LEAD: begin
          st  <= p_igd ? ISLAND : CONTROL;
          pkt <= '0;
        end
        ISLAND: begin
          if (pkt == '0 && p_igd) begin
            st <= ISL_TRAIL;
          end else if (all_terc) begin
            island_valid <= 1'b1;
            island_data  <= {p2.terc, p1.terc, p0.terc};
            packet_start <= (pkt == '0);
            pkt          <= (pkt == PKT_LAST) ? '0 : pkt + PW'(1);
          end else begin
            st <= CONTROL;
          end
        end
        ISL_TRAIL: st <= CONTROL;
        default:   st <= CONTROL;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_tmds_period_decode.sv
// Directed bench for tmds_period_decode: video, island, error and reset scenarios.
module tb_tmds_period_decode;

  localparam logic [9:0] C00 = 10'h354;
  localparam logic [9:0] C01 = 10'h0AB;
  localparam logic [9:0] C11 = 10'h2AB;
  localparam logic [9:0] GBA = 10'h2CC;
  localparam logic [9:0] GBB = 10'h133;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  in0, in1, in2;

  logic [2:0]  state, state4;
  logic        video_valid, video_valid4;
  logic [23:0] rgb, rgb4;
  logic        island_valid, island_valid4;
  logic [11:0] island_data, island_data4;
  logic        packet_start, packet_start4;
  logic        hsync, hsync4, vsync, vsync4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;

  int n_run = 0;
  int n_fail = 0;

  tmds_period_decode dut (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2),
    .state(state), .video_valid(video_valid), .rgb(rgb),
    .island_valid(island_valid), .island_data(island_data),
    .packet_start(packet_start), .hsync(hsync), .vsync(vsync),
    .err_count(err_count)
  );

  tmds_period_decode #(.ERR_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2),
    .state(state4), .video_valid(video_valid4), .rgb(rgb4),
    .island_valid(island_valid4), .island_data(island_data4),
    .packet_start(packet_start4), .hsync(hsync4), .vsync(vsync4),
    .err_count(err_count4)
  );

  always #5 clk = ~clk;

  // cycle stamps and event tallies
  int   pcyc = 0;
  int   vv_tot = 0, vv_first = 0, iv_tot = 0, ps_tot = 0, ps_last = 0, ps_prev = 0;
  logic vv_prev = 1'b0;

  always @(posedge clk) pcyc++;

  always @(negedge clk) begin
    if (video_valid) begin
      vv_tot++;
      if (!vv_prev) vv_first = pcyc;
    end
    vv_prev = video_valid;
    if (island_valid) iv_tot++;
    if (packet_start) begin
      ps_tot++;
      ps_prev = ps_last;
      ps_last = pcyc;
    end
  end

  function automatic logic [9:0] t4(input int n);
    case (n % 16)
      0: return 10'h29C;  1: return 10'h263;  2: return 10'h2E4;  3: return 10'h2E2;
      4: return 10'h171;  5: return 10'h11E;  6: return 10'h18E;  7: return 10'h13C;
      8: return 10'h2CC;  9: return 10'h139; 10: return 10'h19C; 11: return 10'h2C6;
      12: return 10'h28E; 13: return 10'h271; 14: return 10'h163; default: return 10'h2C3;
    endcase
  endfunction

  function automatic logic [11:0] isl_exp(input int k);
    logic [3:0] a, b, c;
    a = 4'((k * 5) % 16);
    b = 4'((k + 3) % 16);
    c = 4'(k % 16);
    return {a, b, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
    @(negedge clk);
    in0 = b;
    in1 = g;
    in2 = r;
  endtask

  task automatic idle(input int n);
    repeat (n) put(C00, C00, C00);
  endtask

  task automatic vid_pre(input int n);
    repeat (n) put(C00, C01, C00);
  endtask

  task automatic isl_pre(input int n);
    repeat (n) put(C00, C01, C01);
  endtask

  task automatic vid_gd();
    put(GBA, GBB, GBA);
  endtask

  task automatic isl_gd(input int ch0_nib);
    put(t4(ch0_nib), GBB, GBB);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0c, v0, iv0, ps0;
    reset = 1'b1;
    in0 = C00; in1 = C00; in2 = C00;
    repeat (3) @(negedge clk);

    chk("rst_state", 32'(state), 32'd0);
    chk("rst_vv", 32'(video_valid), 32'd0);
    chk("rst_iv", 32'(island_valid), 32'd0);
    chk("rst_ps", 32'(packet_start), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_idat", 32'(island_data), 32'd0);
    chk("rst_hs", 32'(hsync), 32'd0);
    chk("rst_vs", 32'(vsync), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    reset = 1'b0;

    // short preamble never arms, guards ignored
    vid_pre(7);
    vid_gd();
    vid_gd();
    idle(3);
    chk("short_state", 32'(state), 32'd0);
    chk("short_err", 32'(err_count), 32'd0);
    chk("short_vv", 32'(vv_tot), 32'd0);

    // full video period
    vid_pre(8);
    vid_gd();
    vid_gd();
    put(10'h100, 10'h1FF, 10'h2FF);
    d0c = pcyc;
    chk("vid_guard_state", 32'(state), 32'd1);
    put(10'h3AA, 10'h10F, 10'h0F0);
    chk("video_state", 32'(state), 32'd2);
    put(10'h233, 10'h100, 10'h3AA);
    chk("rgb0", 32'(rgb), 32'hFE0100);
    chk("vv0", 32'(video_valid), 32'd1);
    put(10'h0F0, 10'h233, 10'h10F);
    chk("rgb1", 32'(rgb), 32'hEE11FF);
    put(C11, C00, C00);
    chk("rgb2", 32'(rgb), 32'hFF00AA);
    put(C11, C00, C00);
    chk("rgb3", 32'(rgb), 32'h11AAEE);
    put(C11, C00, C00);
    chk("vid_end_state", 32'(state), 32'd0);
    chk("vid_end_vv", 32'(video_valid), 32'd0);
    chk("vid_end_hs", 32'(hsync), 32'd1);
    chk("vid_end_vs", 32'(vsync), 32'd1);
    chk("vv_count", 32'(vv_tot), 32'd4);
    chk("vv_latency", 32'(vv_first - d0c), 32'd2);

    // island with two packets
    iv0 = iv_tot;
    ps0 = ps_tot;
    isl_pre(8);
    isl_gd(12);
    isl_gd(12);
    for (int k = 0; k < 64; k++) begin
      put(t4(k), t4(k + 3), t4(k * 5));
      if (k >= 2) chk("isl_dat", 32'(island_data), 32'(isl_exp(k - 2)));
      if (k == 2) chk("isl_ps_first", 32'(packet_start), 32'd1);
      if (k == 3) chk("isl_ps_second", 32'(packet_start), 32'd0);
      if (k == 5) chk("isl_state", 32'(state), 32'd4);
    end
    chk("isl_hs", 32'(hsync), 32'd1);
    chk("isl_vs", 32'(vsync), 32'd0);
    isl_gd(3);
    isl_gd(3);
    idle(3);
    chk("isl_end_state", 32'(state), 32'd0);
    chk("isl_iv_count", 32'(iv_tot - iv0), 32'd64);
    chk("isl_ps_count", 32'(ps_tot - ps0), 32'd2);
    chk("isl_ps_spacing", 32'(ps_last - ps_prev), 32'd32);
    chk("isl_err", 32'(err_count), 32'd0);

    // bad channel mid-packet
    isl_pre(8);
    isl_gd(12);
    isl_gd(12);
    for (int k = 0; k < 5; k++) put(t4(k), t4(k + 3), t4(k * 5));
    put(t4(0), 10'h155, t4(0));
    idle(3);
    chk("islerr_count", 32'(err_count), 32'd1);
    chk("islerr_state", 32'(state), 32'd0);

    // reset in the middle of video
    vid_pre(8);
    vid_gd();
    vid_gd();
    put(10'h100, 10'h1FF, 10'h2FF);
    put(10'h3AA, 10'h10F, 10'h0F0);
    put(10'h233, 10'h100, 10'h3AA);
    put(10'h0F0, 10'h233, 10'h10F);
    chk("pre_rst_vv", 32'(video_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_vv", 32'(video_valid), 32'd0);
    chk("arst_rgb", 32'(rgb), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    chk("arst_hs", 32'(hsync), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v0 = vv_tot;
    put(10'h100, 10'h1FF, 10'h2FF);
    put(10'h3AA, 10'h10F, 10'h0F0);
    vid_gd();
    vid_gd();
    put(10'h233, 10'h100, 10'h3AA);
    put(10'h0F0, 10'h233, 10'h10F);
    idle(3);
    chk("post_rst_vv", 32'(vv_tot - v0), 32'd0);
    chk("post_rst_state", 32'(state), 32'd0);

    // error counter saturation on the narrow instance
    repeat (13) begin
      vid_pre(8);
      vid_gd();
      idle(1);
    end
    idle(2);
    chk("err13", 32'(err_count), 32'd13);
    chk("err13_w4", 32'(err_count4), 32'd13);
    repeat (7) begin
      vid_pre(8);
      vid_gd();
      idle(1);
    end
    idle(2);
    chk("err20", 32'(err_count), 32'd20);
    chk("err_sat_w4", 32'(err_count4), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
